// File: rtl/vector_list_engine.sv
`default_nettype none
// ============================================================================
// vector_list_engine : display-list fetcher with Bresenham rasteriser for X/Y DACs
// Feature macro: VECTOR_DWELL_EN (blanked settle after each MOVE / LINE). Rev 1.0
// ============================================================================
module vector_list_engine #(
   parameter int COORD_W      = 8,
   parameter int ADDRESSWIDTH = 8,
   parameter int DATAWIDTH    = 2*COORD_W+2,
   parameter int MEM_LAT      = 1,
   parameter int LOOP         = 1,
   parameter int DWELL        = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    start,
   input  logic [ADDRESSWIDTH-1:0] base_addr,
   output logic [ADDRESSWIDTH-1:0] addr,
   input  logic [DATAWIDTH-1:0]    data_in,
   output logic [COORD_W-1:0]      x_ch,
   output logic [COORD_W-1:0]      y_ch,
   output logic                    beam_on,
   output logic                    busy,
   output logic                    frame_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_DECODE = 3'd3,
      S_DRAW   = 3'd4,
`ifdef VECTOR_DWELL_EN
      S_DWELL  = 3'd5,
`endif
      S_ENDF   = 3'd6
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDRESSWIDTH-1:0]  ptr_q, ptr_d, addr_q, addr_d;
   logic [COORD_W-1:0]       x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
   logic signed [COORD_W:0]  dx_q, dx_d, dy_q, dy_d;
   logic signed [COORD_W+1:0] err_q, err_d;
   logic                     sx_q, sx_d, sy_q, sy_d;
   logic [1:0]               lat_q, lat_d;
   logic                     beam_q, beam_d, busy_q, done_q;
   logic                     word_done, advance;

`ifdef VECTOR_DWELL_EN
   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   logic [DW_W-1:0]          dwell_q, dwell_d;
`else
   logic [31:0]              w_dwell_unused;
   assign w_dwell_unused = 32'(DWELL);
`endif

   // Word fields
   logic                     w_pos, w_line;
   logic [COORD_W-1:0]       w_xin, w_yin;
   assign w_pos  = data_in[0];
   assign w_line = data_in[1];
   assign w_xin  = data_in[2 +: COORD_W];
   assign w_yin  = data_in[2+COORD_W +: COORD_W];

   // Line setup from the current point to the fetched endpoint
   logic [COORD_W:0]         w_xdiff, w_ydiff, w_dxabs, w_dyneg;
   assign w_xdiff = {1'b0, w_xin} - {1'b0, x_q};
   assign w_ydiff = {1'b0, w_yin} - {1'b0, y_q};
   assign w_dxabs = w_xdiff[COORD_W] ? -w_xdiff : w_xdiff;
   assign w_dyneg = w_ydiff[COORD_W] ? w_ydiff : -w_ydiff;

   // One Bresenham step; e2 needs one extra bit over err
   logic signed [COORD_W+2:0] w_e2, w_dx_e2, w_dy_e2;
   logic signed [COORD_W+1:0] w_dx_ext, w_dy_ext, w_errn;
   logic                      w_stepx, w_stepy, w_at_end;
   logic [COORD_W-1:0]        w_xn, w_yn;
   assign w_e2     = {err_q, 1'b0};
   assign w_dx_e2  = {{2{dx_q[COORD_W]}}, dx_q};
   assign w_dy_e2  = {{2{dy_q[COORD_W]}}, dy_q};
   assign w_dx_ext = {dx_q[COORD_W], dx_q};
   assign w_dy_ext = {dy_q[COORD_W], dy_q};
   assign w_stepx  = (w_e2 >= w_dy_e2);
   assign w_stepy  = (w_e2 <= w_dx_e2);
   assign w_xn     = w_stepx ? (sx_q ? x_q - COORD_W'(1) : x_q + COORD_W'(1)) : x_q;
   assign w_yn     = w_stepy ? (sy_q ? y_q - COORD_W'(1) : y_q + COORD_W'(1)) : y_q;
   assign w_errn   = err_q + (w_stepx ? w_dy_ext : '0) + (w_stepy ? w_dx_ext : '0);
   assign w_at_end = (x_q == tx_q) && (y_q == ty_q);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      x_d       = x_q;
      y_d       = y_q;
      tx_d      = tx_q;
      ty_d      = ty_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      err_d     = err_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      lat_d     = lat_q;
      beam_d    = 1'b0;
      word_done = 1'b0;
      advance   = 1'b0;
`ifdef VECTOR_DWELL_EN
      dwell_d   = dwell_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d   = base_addr;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (MEM_LAT > 1) begin
               lat_d   = 2'(MEM_LAT-2);
               state_d = S_WAIT;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_WAIT: begin
            if (lat_q == 2'd0) state_d = S_DECODE;
            else               lat_d   = lat_q - 2'd1;
         end
         S_DECODE: begin
            if (w_line) begin
               tx_d    = w_xin;
               ty_d    = w_yin;
               dx_d    = w_dxabs;
               dy_d    = w_dyneg;
               err_d   = {w_dxabs[COORD_W], w_dxabs} + {w_dyneg[COORD_W], w_dyneg};
               sx_d    = w_xdiff[COORD_W];
               sy_d    = w_ydiff[COORD_W];
               state_d = S_DRAW;
            end else if (w_pos) begin
               x_d       = w_xin;
               y_d       = w_yin;
               word_done = 1'b1;
            end else begin
               state_d = S_ENDF;
            end
         end
         S_DRAW: begin
            beam_d = 1'b1;
            // Already at the endpoint only for a zero-length line: show a dot
            if (w_at_end) begin
               word_done = 1'b1;
            end else begin
               x_d   = w_xn;
               y_d   = w_yn;
               err_d = w_errn;
               if ((w_xn == tx_q) && (w_yn == ty_q)) word_done = 1'b1;
            end
         end
`ifdef VECTOR_DWELL_EN
         S_DWELL: begin
            if (dwell_q == '0) advance = 1'b1;
            else               dwell_d = dwell_q - DW_W'(1);
         end
`endif
         S_ENDF: begin
            if ((LOOP != 0) && start) begin
               ptr_d   = base_addr;
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (word_done) begin
`ifdef VECTOR_DWELL_EN
         if (DWELL > 0) begin
            state_d = S_DWELL;
            dwell_d = DW_W'(DWELL-1);
         end else begin
            advance = 1'b1;
         end
`else
         advance = 1'b1;
`endif
      end

      // The last address has no successor: the frame ends there
      if (advance) begin
         if (ptr_q == '1) begin
            state_d = S_ENDF;
         end else begin
            ptr_d   = ptr_q + ADDRESSWIDTH'(1);
            state_d = S_FETCH;
         end
      end

      addr_d = (state_d == S_FETCH) ? ptr_d : addr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         addr_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         tx_q    <= '0;
         ty_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         lat_q   <= '0;
         beam_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef VECTOR_DWELL_EN
         dwell_q <= '0;
`endif
      end else if (!enable) begin
         beam_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         lat_q   <= lat_d;
         beam_q  <= beam_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_ENDF);
`ifdef VECTOR_DWELL_EN
         dwell_q <= dwell_d;
`endif
      end
   end

   assign addr       = addr_q;
   assign x_ch       = x_q;
   assign y_ch       = y_q;
   assign beam_on    = beam_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_list_engine.sv
`default_nettype none
// tb_vector_list_engine : directed checks of fetch timing, line drawing, looping,
// enable gating, reset abort and address wrap on two engine configurations.
module tb_vector_list_engine;
   localparam int CW = 8;
   localparam int AW = 8;
   localparam int DW = 2*CW+2;
`ifdef VECTOR_DWELL_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, enable, start_a, start_b;
   logic [AW-1:0] base_a, base_b, addr_a, addr_b;
   logic [CW-1:0] x_a, y_a, x_b, y_b;
   logic          beam_a, busy_a, done_a, beam_b, busy_b, done_b;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_a, p1, p2, p3;

   // Memory models: one-cycle and three-cycle read pipelines
   always @(posedge clk) begin
      rd_a <= mem[addr_a];
      p1   <= mem[addr_b];
      p2   <= p1;
      p3   <= p2;
   end

   vector_list_engine #(.COORD_W(CW), .ADDRESSWIDTH(AW), .MEM_LAT(1), .LOOP(1), .DWELL(2)) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable), .start(start_a), .base_addr(base_a),
      .addr(addr_a), .data_in(rd_a), .x_ch(x_a), .y_ch(y_a),
      .beam_on(beam_a), .busy(busy_a), .frame_done(done_a));

   vector_list_engine #(.COORD_W(CW), .ADDRESSWIDTH(AW), .MEM_LAT(3), .LOOP(1), .DWELL(0)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable), .start(start_b), .base_addr(base_b),
      .addr(addr_b), .data_in(p3), .x_ch(x_b), .y_ch(y_b),
      .beam_on(beam_b), .busy(busy_b), .frame_done(done_b));

   int n_checks = 0;
   int n_fail   = 0;
   int tr_x[40], tr_y[40], tr_b[40], tr_d[40], tr_busy[40], tr_addr[40];
   int lit_x[$], lit_y[$];
   int lit_cnt, first_lit, done_cnt, first_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mv(input int x, input int y);
      return {8'(y), 8'(x), 2'b01};
   endfunction

   function automatic logic [DW-1:0] ln(input int x, input int y);
      return {8'(y), 8'(x), 2'b10};
   endfunction

   task automatic go(input bit selb, input logic [AW-1:0] base);
      @(negedge clk);
      if (selb) begin base_b = base; start_b = 1'b1; end
      else      begin base_a = base; start_a = 1'b1; end
   endtask

   // Record n cycles starting with the first FETCH cycle
   task automatic capture(input int n, input bit selb, input int start_drop, input int en_s, input int en_n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tr_x[i]    = selb ? int'(x_b)    : int'(x_a);
         tr_y[i]    = selb ? int'(y_b)    : int'(y_a);
         tr_b[i]    = selb ? int'(beam_b) : int'(beam_a);
         tr_d[i]    = selb ? int'(done_b) : int'(done_a);
         tr_busy[i] = selb ? int'(busy_b) : int'(busy_a);
         tr_addr[i] = selb ? int'(addr_b) : int'(addr_a);
         if (i >= start_drop) begin start_a = 1'b0; start_b = 1'b0; end
         enable = !((i >= en_s) && (i < en_s + en_n));
      end
   endtask

   task automatic scan(input int n);
      lit_x.delete(); lit_y.delete();
      lit_cnt = 0; done_cnt = 0; first_lit = -1; first_done = -1;
      for (int i = 0; i < n; i++) begin
         if (tr_b[i] == 1) begin
            lit_cnt++;
            lit_x.push_back(tr_x[i]);
            lit_y.push_back(tr_y[i]);
            if (first_lit < 0) first_lit = i;
         end
         if (tr_d[i] == 1) begin
            done_cnt++;
            if (first_done < 0) first_done = i;
         end
      end
   endtask

   function automatic int lx(input int i);
      return (i < lit_x.size()) ? lit_x[i] : -1;
   endfunction

   function automatic int ly(input int i);
      return (i < lit_y.size()) ? lit_y[i] : -1;
   endfunction

   int ex7[7] = '{1, 2, 3, 4, 5, 6, 7};
   int ey7[7] = '{0, 1, 1, 2, 2, 3, 3};
   int bad;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h00] = mv(10, 20); mem[8'h01] = ln(13, 21); mem[8'h02] = '0;
      mem[8'h10] = mv(3, 4);   mem[8'h11] = '0;
      mem[8'h20] = mv(5, 5);   mem[8'h21] = ln(5, 5);   mem[8'h22] = '0;
      mem[8'h30] = mv(0, 0);   mem[8'h31] = ln(7, 3);   mem[8'h32] = '0;
      mem[8'hFF] = mv(1, 1);
      rst = 1'b1; enable = 1'b1; start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0;
      repeat (3) @(negedge clk);
      check("rst_addr", addr_a, 0);
      check("rst_x", x_a, 0);
      check("rst_y", y_a, 0);
      check("rst_beam", beam_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // MOVE(10,20), LINE(13,21), END
      go(1'b0, 8'h00);
      capture(20, 1'b0, 0, -1, 0);
      scan(20);
      check("t1_addr0", tr_addr[0], 8'h00);
      check("t1_busy0", tr_busy[0], 1);
      check("t1_move_x", tr_x[2], 10);
      check("t1_move_y", tr_y[2], 20);
      check("t1_move_beam", tr_b[2], 0);
      check("t1_addr_next", tr_addr[2+D], 8'h01);
      check("t1_first_lit", first_lit, 5+D);
      check("t1_lit_cnt", lit_cnt, 3);
      check("t1_p0x", lx(0), 11); check("t1_p0y", ly(0), 20);
      check("t1_p1x", lx(1), 12); check("t1_p1y", ly(1), 21);
      check("t1_p2x", lx(2), 13); check("t1_p2y", ly(2), 21);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_done_cyc", first_done, 9+2*D);
      check("t1_busy_endf", tr_busy[9+2*D], 1);
      check("t1_busy_fall", tr_busy[10+2*D], 0);

      // Zero-length line is a single lit dot
      go(1'b0, 8'h20);
      capture(20, 1'b0, 0, -1, 0);
      scan(20);
      check("t2_lit_cnt", lit_cnt, 1);
      check("t2_dot_x", lx(0), 5);
      check("t2_dot_y", ly(0), 5);
      check("t2_first_lit", first_lit, 5+D);
      check("t2_done_cyc", first_done, 7+2*D);

      // Enable dropped for 5 cycles in the middle of (0,0)->(7,3)
      go(1'b0, 8'h30);
      capture(34, 1'b0, 0, 6+D, 5);
      scan(34);
      for (int i = 7+D; i < 12+D; i++) begin
         check("t3_gap_beam", tr_b[i], 0);
         check("t3_gap_x", tr_x[i], 2);
         check("t3_gap_y", tr_y[i], 1);
      end
      check("t3_lit_cnt", lit_cnt, 7);
      for (int i = 0; i < 7; i++) begin
         check("t3_px", lx(i), ex7[i]);
         check("t3_py", ly(i), ey7[i]);
      end
      check("t3_done_cnt", done_cnt, 1);
      check("t3_done_cyc", first_done, 18+2*D);

      // MOVE at the last address ends the frame without wrapping
      go(1'b0, 8'hFF);
      capture(12, 1'b0, 0, -1, 0);
      scan(12);
      bad = 0;
      for (int i = 0; i < 12; i++) if (tr_addr[i] != 8'hFF) bad++;
      check("t4_addr_nowrap", bad, 0);
      check("t4_x", tr_x[2], 1);
      check("t4_y", tr_y[2], 1);
      check("t4_lit_cnt", lit_cnt, 0);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_done_cyc", first_done, 2+D);
      check("t4_busy_fall", tr_busy[3+D], 0);

      // Looping, three-cycle memory, start released during frame two
      go(1'b1, 8'h10);
      capture(24, 1'b1, 12, -1, 0);
      scan(24);
      check("t6_addr0", tr_addr[0], 8'h10);
      check("t6_move_x", tr_x[4], 3);
      check("t6_move_y", tr_y[4], 4);
      check("t6_addr4", tr_addr[4], 8'h11);
      check("t6_done_first", first_done, 8);
      check("t6_addr_reload", tr_addr[9], 8'h10);
      check("t6_done2", tr_d[17], 1);
      check("t6_done_cnt", done_cnt, 2);
      check("t6_busy_endf", tr_busy[17], 1);
      check("t6_busy_fall", tr_busy[18], 0);

      // Reset during DRAW aborts with no frame_done
      go(1'b0, 8'h00);
      capture(6+D, 1'b0, 0, -1, 0);
      check("t5_pre_beam", tr_b[5+D], 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_addr", addr_a, 0);
      check("t5_x", x_a, 0);
      check("t5_y", y_a, 0);
      check("t5_beam", beam_a, 0);
      check("t5_busy", busy_a, 0);
      check("t5_done", done_a, 0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done_a || busy_a) bad++;
      end
      check("t5_quiet_after", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
